// File: rtl/axis_frame_engine_if.sv
// AXI-Stream link bundle shared by the slave and master sides of the frame engine.
interface axis_frame_engine_if #(
  parameter int DATA_W = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_frame_engine.sv
// Wraps a start/done compute core with AXI-Stream framing: collect IN_WORDS, run core,
// stream OUT_WORDS back with TLAST. Handles short/long frames, core timeout, frame count.
//
// state | meaning
// RECV  | accepting input words into in_buf
// DRAIN | buffer full, discarding surplus words until tlast
// PROC  | core running on core_din, waiting for done or timeout
// SEND  | streaming out_buf on the master side
module axis_frame_engine #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int IN_WORDS           = 20,
  parameter int OUT_WORDS          = 8,
  parameter int TIMEOUT_CYCLES     = 0
) (
  input  logic                                     s00_axis_aclk,
  input  logic                                     s00_axis_aresetn,
  axis_frame_engine_if.slave                       s00_axis,
  axis_frame_engine_if.master                      m00_axis,
  output logic                                     core_start,
  output logic [IN_WORDS*C_AXIS_TDATA_WIDTH-1:0]   core_din,
  input  logic                                     core_done,
  input  logic [OUT_WORDS*C_AXIS_TDATA_WIDTH-1:0]  core_dout,
  output logic                                     busy,
  output logic                                     err_short,
  output logic                                     err_long,
  output logic                                     err_timeout,
  output logic [15:0]                              frame_cnt
);

  localparam int W   = C_AXIS_TDATA_WIDTH;
  localparam int WPW = $clog2(IN_WORDS  > 2 ? IN_WORDS  : 2);
  localparam int RPW = $clog2(OUT_WORDS > 2 ? OUT_WORDS : 2);
  localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [WPW-1:0] WR_LAST  = WPW'(IN_WORDS - 1);
  localparam logic [RPW-1:0] RD_LAST  = RPW'(OUT_WORDS - 1);
  localparam logic [TW-1:0]  TMO_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {RECV, DRAIN, PROC, SEND} state_t;

  state_t           state_q, state_d;
  logic [WPW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [RPW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             start_q, start_d;
  logic             tready_q, tready_d;
  logic             tvalid_q, tvalid_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [W-1:0]     in_buf_q  [IN_WORDS];
  logic [W-1:0]     in_buf_d  [IN_WORDS];
  logic [W-1:0]     out_buf_q [OUT_WORDS];
  logic [W-1:0]     out_buf_d [OUT_WORDS];

  logic in_xfer, out_xfer;
  logic unused_tstrb;

  assign in_xfer      = s00_axis.tvalid && tready_q;
  assign out_xfer     = tvalid_q && m00_axis.tready;
  assign unused_tstrb = ^s00_axis.tstrb;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tmo_cnt_d   = tmo_cnt_q;
    start_d     = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    err_timeout = 1'b0;
    frame_cnt_d = frame_cnt_q;
    in_buf_d    = in_buf_q;
    out_buf_d   = out_buf_q;

    case (state_q)
      RECV: begin
        if (in_xfer) begin
          in_buf_d[wr_ptr_q] = s00_axis.tdata;
          if (s00_axis.tlast) begin
            wr_ptr_d = '0;
            if (wr_ptr_q == WR_LAST) begin
              state_d   = PROC;
              start_d   = 1'b1;
              tmo_cnt_d = TMO_LOAD;
            end else begin
              err_short_d = 1'b1;
            end
          end else if (wr_ptr_q == WR_LAST) begin
            // Pointer parks on the last slot; surplus words never reach in_buf.
            state_d = DRAIN;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (in_xfer && s00_axis.tlast) begin
          err_long_d = 1'b1;
          state_d    = PROC;
          start_d    = 1'b1;
          tmo_cnt_d  = TMO_LOAD;
          wr_ptr_d   = '0;
        end
      end
      PROC: begin
        if (core_done) begin
          for (int i = 0; i < OUT_WORDS; i++) begin
            out_buf_d[i] = core_dout[(OUT_WORDS-1-i)*W +: W];
          end
          rd_ptr_d = '0;
          state_d  = SEND;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == '0)) begin
          err_timeout = 1'b1;
          state_d     = RECV;
        end else if (tmo_cnt_q != '0) begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (rd_ptr_q == RD_LAST) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            wr_ptr_d    = '0;
            state_d     = RECV;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = RECV;
    endcase

    // Handshake outputs are registered decodes of the next state.
    tready_d = (state_d == RECV) || (state_d == DRAIN);
    tvalid_d = (state_d == SEND);
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q     <= RECV;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      start_q     <= 1'b0;
      tready_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      start_q     <= start_d;
      tready_q    <= tready_d;
      tvalid_q    <= tvalid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    in_buf_q  <= in_buf_d;
    out_buf_q <= out_buf_d;
  end

  for (genvar g = 0; g < IN_WORDS; g++) begin : g_din
    assign core_din[(IN_WORDS-1-g)*W +: W] = in_buf_q[g];
  end

  assign s00_axis.tready = tready_q;
  assign m00_axis.tvalid = tvalid_q;
  assign m00_axis.tdata  = tvalid_q ? out_buf_q[rd_ptr_q] : '0;
  assign m00_axis.tlast  = tvalid_q && (rd_ptr_q == RD_LAST);
  assign m00_axis.tstrb  = '1;

  assign core_start = start_q;
  assign busy       = (state_q != RECV);
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_engine.sv
// Self-checking bench for axis_frame_engine with a 3-cycle XOR/ADD model core.
module tb_axis_frame_engine;

  localparam int W     = 32;
  localparam int IN_W  = 4;
  localparam int OUT_W = 2;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_frame_engine_if #(.DATA_W(W)) s_if ();
  axis_frame_engine_if #(.DATA_W(W)) m_if ();

  logic                 core_start, core_done, busy, err_short, err_long, err_timeout;
  logic [IN_W*W-1:0]    core_din;
  logic [OUT_W*W-1:0]   core_dout;
  logic [15:0]          frame_cnt;

  axis_frame_engine #(
    .C_AXIS_TDATA_WIDTH(W), .IN_WORDS(IN_W), .OUT_WORDS(OUT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis(s_if), .m00_axis(m_if),
    .core_start(core_start), .core_din(core_din), .core_done(core_done),
    .core_dout(core_dout), .busy(busy), .err_short(err_short), .err_long(err_long),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  // Model core: done exactly 3 cycles after start unless told to hang.
  int          core_cnt;
  logic        core_hang;
  logic [31:0] res0, res1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) core_cnt <= 0;
    else if (core_start && !core_hang) begin
      core_cnt <= 3;
      res0 <= core_din[127:96] ^ core_din[95:64];
      res1 <= core_din[63:32] + core_din[31:0];
    end else if (core_cnt > 0) core_cnt <= core_cnt - 1;
  end
  assign core_done = (core_cnt == 1);
  assign core_dout = {res0, res1};

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  // Passive monitor: records events with cycle stamps, sampled at negedge.
  int          cyc = 0;
  logic [31:0] out_q[$];
  logic        out_last_q[$];
  int          out_cyc_q[$];
  int n_start, start_cyc, n_short, n_long, long_cyc, n_tmo, tmo_cyc, in_cyc, vrise_cyc;
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (m_if.tvalid && m_if.tready) begin
      out_q.push_back(m_if.tdata);
      out_last_q.push_back(m_if.tlast);
      out_cyc_q.push_back(cyc);
    end
    if (core_start) begin n_start++; start_cyc = cyc; end
    if (err_short) n_short++;
    if (err_long) begin n_long++; long_cyc = cyc; end
    if (err_timeout) begin n_tmo++; tmo_cyc = cyc; end
    if (s_if.tvalid && s_if.tready) in_cyc = cyc;
    if (m_if.tvalid && !prev_v) vrise_cyc = cyc;
    prev_v = m_if.tvalid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete(); out_last_q.delete(); out_cyc_q.delete();
    n_start = 0; n_short = 0; n_long = 0; n_tmo = 0;
    start_cyc = -1; long_cyc = -1; tmo_cyc = -1; in_cyc = -1; vrise_cyc = -1;
  endtask

  task automatic send_words(input int n, input logic [31:0] w[8], input int max_gap);
    for (int i = 0; i < n; i++) begin
      int   b;
      logic acc;
      s_if.tvalid = 1'b0;
      repeat ($urandom_range(0, max_gap)) tick();
      s_if.tvalid = 1'b1;
      s_if.tdata  = w[i];
      s_if.tlast  = (i == n - 1);
      b = 0;
      do begin
        acc = s_if.tready;
        tick();
        b++;
      end while (!acc && b < 100);
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL send_accept word %0d: not accepted within %0d cycles", i, b);
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output logic ok);
    int k = 0;
    while (busy && k < bound) begin tick(); k++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", s_if.tready); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_if.tvalid); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_if.tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start got %b want 0", core_start); end
    checks++; if ({err_short, err_long, err_timeout} !== 3'b000) begin errors++; $display("FAIL rst_errs got %b want 000", {err_short, err_long, err_timeout}); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    exp_frames = 0;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready got %b want 1", s_if.tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [31:0] w[8];
    logic ok;
    w = '{1, 2, 3, 4, 0, 0, 0, 0};
    clear_mon();
    m_if.tready = 1'b1;
    send_words(4, w, 0);
    wait_idle(50, ok);
    tick();
    exp_frames++;
    checks++; if (!ok) begin errors++; $display("FAIL basic_idle busy stuck"); end
    checks++; if (n_start !== 1 || start_cyc !== in_cyc + 1) begin errors++; $display("FAIL basic_start n=%0d cyc=%0d want 1 at %0d", n_start, start_cyc, in_cyc + 1); end
    checks++; if (vrise_cyc !== start_cyc + 4) begin errors++; $display("FAIL basic_tvalid_latency got %0d want %0d", vrise_cyc, start_cyc + 4); end
    checks++;
    if (out_q.size() !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", out_q.size()); end
    else begin
      checks++; if (out_q[0] !== 32'h3 || out_q[1] !== 32'h7) begin errors++; $display("FAIL basic_data got %h %h want 3 7", out_q[0], out_q[1]); end
      checks++; if (out_last_q[0] !== 1'b0 || out_last_q[1] !== 1'b1) begin errors++; $display("FAIL basic_tlast got %b%b want 01", out_last_q[0], out_last_q[1]); end
      checks++; if (out_cyc_q[1] !== out_cyc_q[0] + 1) begin errors++; $display("FAIL basic_rate gap got %0d want 1", out_cyc_q[1] - out_cyc_q[0]); end
    end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL basic_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_short();
    logic [31:0] w[8];
    logic ok;
    w = '{1, 2, 3, 4, 0, 0, 0, 0};
    clear_mon();
    send_words(3, w, 0);
    tick(); tick();
    checks++; if (n_short !== 1) begin errors++; $display("FAIL short_err got %0d want 1", n_short); end
    checks++; if (n_start !== 0) begin errors++; $display("FAIL short_no_start got %0d want 0", n_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got %b want 0", busy); end
    send_words(4, w, 1);
    wait_idle(50, ok);
    tick();
    exp_frames++;
    checks++;
    if (out_q.size() !== 2) begin errors++; $display("FAIL short_follow_count got %0d want 2", out_q.size()); end
    else if (out_q[0] !== 32'h3 || out_q[1] !== 32'h7) begin errors++; $display("FAIL short_follow_data got %h %h want 3 7", out_q[0], out_q[1]); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL short_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_long();
    logic [31:0] w[8];
    logic ok;
    int last_in;
    w = '{1, 2, 3, 4, 5, 6, 0, 0};
    clear_mon();
    send_words(6, w, 0);
    last_in = in_cyc;
    wait_idle(50, ok);
    tick();
    exp_frames++;
    checks++; if (n_long !== 1 || long_cyc !== last_in + 1) begin errors++; $display("FAIL long_err n=%0d cyc=%0d want 1 at %0d", n_long, long_cyc, last_in + 1); end
    checks++; if (start_cyc !== last_in + 1) begin errors++; $display("FAIL long_start got %0d want %0d", start_cyc, last_in + 1); end
    checks++;
    if (out_q.size() !== 2) begin errors++; $display("FAIL long_count got %0d want 2", out_q.size()); end
    else if (out_q[0] !== 32'h3 || out_q[1] !== 32'h7) begin errors++; $display("FAIL long_data got %h %h want 3 7", out_q[0], out_q[1]); end
  endtask

  task automatic test_timeout();
    logic [31:0] w[8];
    logic ok;
    w = '{1, 2, 3, 4, 0, 0, 0, 0};
    clear_mon();
    core_hang = 1'b1;
    send_words(4, w, 0);
    wait_idle(60, ok);
    tick(); tick();
    core_hang = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL tmo_idle busy stuck"); end
    checks++; if (n_tmo !== 1 || tmo_cyc !== start_cyc + TMO - 1) begin errors++; $display("FAIL tmo_pulse n=%0d cyc=%0d want 1 at %0d", n_tmo, tmo_cyc, start_cyc + TMO - 1); end
    checks++; if (out_q.size() !== 0 || vrise_cyc !== -1) begin errors++; $display("FAIL tmo_no_output got %0d words want 0", out_q.size()); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL tmo_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
    clear_mon();
    w = '{5, 6, 7, 8, 0, 0, 0, 0};
    send_words(4, w, 0);
    wait_idle(50, ok);
    tick();
    exp_frames++;
    checks++;
    if (out_q.size() !== 2) begin errors++; $display("FAIL tmo_next_count got %0d want 2", out_q.size()); end
    else if (out_q[0] !== 32'h3 || out_q[1] !== 32'hF) begin errors++; $display("FAIL tmo_next_data got %h %h want 3 f", out_q[0], out_q[1]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[8];
    logic [31:0] held_d;
    logic        held_l, held_v, fin;
    int          xfers, stalls;
    w = '{9, 10, 11, 12, 0, 0, 0, 0};
    clear_mon();
    m_if.tready = 1'b0;
    send_words(4, w, 0);
    held_v = 1'b0; fin = 1'b0; xfers = 0; stalls = 0; held_d = '0; held_l = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      m_if.tready = (k % 2 == 0);
      @(negedge clk);
      if (m_if.tvalid) begin
        if (held_v) begin
          checks++;
          if (m_if.tdata !== held_d || m_if.tlast !== held_l) begin
            errors++;
            $display("FAIL bp_hold got %h/%b want %h/%b", m_if.tdata, m_if.tlast, held_d, held_l);
          end
        end
        if (m_if.tready) begin
          xfers++;
          held_v = 1'b0;
          if (m_if.tlast) begin
            fin = 1'b1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_last got %b want 1", busy); end
          end
        end else begin
          stalls++;
          held_v = 1'b1; held_d = m_if.tdata; held_l = m_if.tlast;
        end
      end
      @(posedge clk);
      #1;
    end
    m_if.tready = 1'b1;
    exp_frames++;
    checks++; if (xfers !== 2 || stalls == 0) begin errors++; $display("FAIL bp_xfers got %0d (stalls %0d) want 2", xfers, stalls); end
    checks++; if (busy !== 1'b0 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL bp_end busy=%b tvalid=%b want 0 0", busy, m_if.tvalid); end
    checks++;
    if (out_q.size() !== 2) begin errors++; $display("FAIL bp_count got %0d want 2", out_q.size()); end
    else if (out_q[0] !== 32'h3 || out_q[1] !== 32'd23) begin errors++; $display("FAIL bp_data got %h %h want 3 17", out_q[0], out_q[1]); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL bp_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_async_reset();
    logic [31:0] w[8];
    logic ok;
    int k;
    w = '{1, 2, 3, 4, 0, 0, 0, 0};
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1; s_if.tdata = 32'hAA; s_if.tlast = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    s_if.tvalid = 1'b0;
    checks++; if (s_if.tready !== 1'b0 || busy !== 1'b0 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL arst_recv tready=%b busy=%b tvalid=%b want 000", s_if.tready, busy, m_if.tvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 0;
    tick();
    m_if.tready = 1'b0;
    send_words(4, w, 0);
    k = 0;
    while (!m_if.tvalid && k < 20) begin tick(); k++; end
    checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL arst_reach_send tvalid=%b want 1", m_if.tvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s_if.tready !== 1'b0 || busy !== 1'b0 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL arst_send tready=%b busy=%b tvalid=%b want 000", s_if.tready, busy, m_if.tvalid); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL arst_frame_cnt got %0d want 0", frame_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    tick();
    clear_mon();
    send_words(4, w, 0);
    wait_idle(50, ok);
    tick();
    exp_frames++;
    checks++;
    if (out_q.size() !== 2) begin errors++; $display("FAIL arst_after_count got %0d want 2", out_q.size()); end
    else if (out_q[0] !== 32'h3 || out_q[1] !== 32'h7) begin errors++; $display("FAIL arst_after_data got %h %h want 3 7", out_q[0], out_q[1]); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL arst_frame_cnt_after got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_random();
    logic [31:0] w[8];
    logic [31:0] exp_q[$];
    int exp_short = 0, exp_long = 0, exp_good = 0, k;
    clear_mon();
    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < 8; i++) w[i] = $urandom();
      // Reference: fewer than IN_W words is dropped; extra words are ignored.
      if (n < IN_W) exp_short++;
      else begin
        exp_q.push_back(w[0] ^ w[1]);
        exp_q.push_back(w[2] + w[3]);
        exp_good++;
        exp_frames++;
        if (n > IN_W) exp_long++;
      end
      send_words(n, w, 2);
      k = 0;
      while (busy && k < 200) begin m_if.tready = $urandom_range(0, 1); tick(); k++; end
      m_if.tready = 1'b1;
    end
    tick(); tick();
    checks++;
    if (out_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", out_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (out_q[i] !== exp_q[i] || out_last_q[i] !== (i % 2 == 1)) begin
          errors++; $display("FAIL rand_word %0d got %h/%b want %h/%b", i, out_q[i], out_last_q[i], exp_q[i], (i % 2 == 1));
        end
      end
    end
    checks++; if (n_short !== exp_short) begin errors++; $display("FAIL rand_short got %0d want %0d", n_short, exp_short); end
    checks++; if (n_long !== exp_long) begin errors++; $display("FAIL rand_long got %0d want %0d", n_long, exp_long); end
    checks++; if (n_start !== exp_good) begin errors++; $display("FAIL rand_starts got %0d want %0d", n_start, exp_good); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL rand_frame_cnt got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  initial begin
    rst_n        = 1'b0;
    core_hang    = 1'b0;
    s_if.tvalid  = 1'b0;
    s_if.tdata   = '0;
    s_if.tstrb   = '1;
    s_if.tlast   = 1'b0;
    m_if.tready  = 1'b1;
    clear_mon();
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_timeout();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
